// File: rtl/rr4_mux_arbiter.sv
// Four-input round-robin arbiter that drives a registered-select data mux.
// Each grant lasts until its requester drops or MAX_HOLD beats are accepted.
module rr4_mux_arbiter #(
  parameter int W        = 1,
  parameter int MAX_HOLD = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [3:0]   req,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  input  logic [W-1:0] d,
  input  logic         out_ready,
  output logic [3:0]   gnt,
  output logic         s1,
  output logic         s2,
  output logic [W-1:0] o,
  output logic         out_valid
);

  typedef enum logic {
    ST_IDLE,
    ST_GRANT
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(MAX_HOLD - 1);

  state_t       r_state;
  logic [1:0]   r_last;
  logic [1:0]   r_sel;
  logic [3:0]   r_cnt;
  logic [3:0]   r_gnt;

  state_t       w_state_nxt;
  logic [1:0]   w_last_nxt;
  logic [1:0]   w_sel_nxt;
  logic [3:0]   w_cnt_nxt;
  logic [3:0]   w_gnt_nxt;

  logic         w_found;
  logic [1:0]   w_win;
  logic         w_own;
  logic         w_valid;
  logic         w_beat;
  logic         w_release;
  logic [W-1:0] w_mux;

  // While granted r_last equals the owner, so one search from r_last covers
  // both the idle case and re-arbitration with the owner ranked last.
  always_comb begin
    w_found = 1'b0;
    w_win   = r_last;
    for (int unsigned k = 1; k <= 4; k++) begin
      if (!w_found && req[r_last + 2'(k)]) begin
        w_found = 1'b1;
        w_win   = r_last + 2'(k);
      end
    end
  end

  always_comb begin
    w_own     = req[r_sel];
    w_valid   = (|r_gnt) & w_own;
    w_beat    = w_valid & out_ready;
    w_release = ~w_own | (w_beat & (r_cnt == CNT_LAST));
  end

  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    w_sel_nxt   = r_sel;
    w_cnt_nxt   = r_cnt;
    w_gnt_nxt   = r_gnt;
    case (r_state)
      ST_IDLE: begin
        w_gnt_nxt = '0;
        if (w_found) begin
          w_state_nxt = ST_GRANT;
          w_last_nxt  = w_win;
          w_sel_nxt   = w_win;
          w_cnt_nxt   = '0;
          w_gnt_nxt   = 4'b0001 << w_win;
        end
      end
      ST_GRANT: begin
        if (w_release) begin
          if (w_found) begin
            w_last_nxt = w_win;
            w_sel_nxt  = w_win;
            w_cnt_nxt  = '0;
            w_gnt_nxt  = 4'b0001 << w_win;
          end else begin
            w_state_nxt = ST_IDLE;
            w_gnt_nxt   = '0;
          end
        end else if (w_beat) begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_gnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_last  <= 2'd3;
      r_sel   <= '0;
      r_cnt   <= '0;
      r_gnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_last  <= w_last_nxt;
      r_sel   <= w_sel_nxt;
      r_cnt   <= w_cnt_nxt;
      r_gnt   <= w_gnt_nxt;
    end
  end

  always_comb begin
    case (r_sel)
      2'd0:    w_mux = a;
      2'd1:    w_mux = b;
      2'd2:    w_mux = c;
      default: w_mux = d;
    endcase
  end

  assign gnt       = r_gnt;
  assign s1        = r_sel[1];
  assign s2        = r_sel[0];
  assign out_valid = w_valid;
  assign o         = w_valid ? w_mux : '0;

endmodule

// File: tb/tb_rr4_mux_arbiter.sv
// Self-checking bench for rr4_mux_arbiter: directed scenarios plus a
// queue-based scoreboard fed by a reference model under random traffic.
module tb_rr4_mux_arbiter;

  localparam int TW = 8;
  localparam int MH = 4;

  logic          clk;
  logic          rst_n;
  logic [3:0]    req;
  logic [TW-1:0] a, b, c, d;
  logic          out_ready;
  logic [3:0]    gnt;
  logic          s1, s2;
  logic [TW-1:0] o;
  logic          out_valid;

  int n_checks;
  int n_errors;

  // reference model state
  bit          m_g;
  logic [1:0]  m_idx;
  logic [1:0]  m_last;
  int          m_cnt;
  int          m_wait[4];
  logic [5:0]  exp_q[$];

  rr4_mux_arbiter #(.W(TW), .MAX_HOLD(MH)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .a(a), .b(b), .c(c), .d(d),
    .out_ready(out_ready), .gnt(gnt), .s1(s1), .s2(s2),
    .o(o), .out_valid(out_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  function automatic logic [TW-1:0] sel_data(input logic [1:0] idx);
    logic [TW-1:0] r;
    if (idx == 2'd0)      r = a;
    else if (idx == 2'd1) r = b;
    else if (idx == 2'd2) r = c;
    else                  r = d;
    return r;
  endfunction

  // returns {found, winner}; searches from+1 .. from+4 modulo 4
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] from);
    int j;
    for (int k = 1; k <= 4; k++) begin
      j = (int'(from) + k) % 4;
      if (r[j]) return {1'b1, 2'(j)};
    end
    return 3'b000;
  endfunction

  task automatic model_reset;
    m_g = 0; m_idx = 2'd0; m_last = 2'd3; m_cnt = 0;
    for (int i = 0; i < 4; i++) m_wait[i] = 0;
  endtask

  task automatic model_step;
    bit         ev;
    bit         own;
    bit         beat;
    logic [2:0] p;
    ev = 0;
    if (!m_g) begin
      p = rr_pick(req, m_last);
      if (p[2]) begin m_g = 1; m_idx = p[1:0]; m_last = p[1:0]; m_cnt = 0; ev = 1; end
    end else begin
      own  = req[m_idx];
      beat = own && out_ready;
      if (!own || (beat && m_cnt == MH - 1)) begin
        p = rr_pick(req, m_idx);
        if (p[2]) begin m_idx = p[1:0]; m_last = p[1:0]; m_cnt = 0; ev = 1; end
        else m_g = 0;
      end else if (beat) begin
        m_cnt = m_cnt + 1;
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (!req[i] || (m_g && m_idx == 2'(i))) m_wait[i] = 0;
      else if (ev) m_wait[i] = m_wait[i] + 1;
    end
    exp_q.push_back({(m_g ? (4'b0001 << m_idx) : 4'b0000), m_idx});
  endtask

  task automatic test_reset;
    req = 4'b1111; out_ready = 1'b1;
    a = 8'h11; b = 8'h22; c = 8'h33; d = 8'h44;
    rst_n = 1'b0;
    #1;
    n_checks++; if (gnt !== 4'b0000) begin n_errors++; $display("FAIL reset_gnt: got %b expected 0000", gnt); end
    n_checks++; if ({s1, s2} !== 2'b00) begin n_errors++; $display("FAIL reset_sel: got %b expected 00", {s1, s2}); end
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    n_checks++; if (o !== 8'h00) begin n_errors++; $display("FAIL reset_o: got %h expected 00", o); end
    tick; tick;
    n_checks++; if (gnt !== 4'b0000) begin n_errors++; $display("FAIL reset_held_gnt: got %b expected 0000", gnt); end
    @(negedge clk); #2; rst_n = 1'b1; #1;
    n_checks++; if (gnt !== 4'b0000) begin n_errors++; $display("FAIL reset_release_gnt: got %b expected 0000", gnt); end
    tick;
    n_checks++; if (gnt !== 4'b0001) begin n_errors++; $display("FAIL reset_first_gnt: got %b expected 0001", gnt); end
  endtask

  task automatic test_single;
    req = 4'b0001; out_ready = 1'b1;
    do_reset;
    tick;
    n_checks++; if (gnt !== 4'b0001) begin n_errors++; $display("FAIL single_gnt: got %b expected 0001", gnt); end
    n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL single_valid: got %b expected 1", out_valid); end
    n_checks++; if (o !== a) begin n_errors++; $display("FAIL single_o: got %h expected %h", o, a); end
    for (int k = 0; k < 8; k++) begin
      tick;
      n_checks++; if (gnt !== 4'b0001 || {s1, s2} !== 2'b00) begin n_errors++; $display("FAIL single_hold[%0d]: got %b/%b expected 0001/00", k, gnt, {s1, s2}); end
    end
    req = 4'b0011;
    for (int k = 0; k < 3; k++) begin
      tick;
      n_checks++; if (gnt !== 4'b0001) begin n_errors++; $display("FAIL single_regrant_cnt[%0d]: got %b expected 0001", k, gnt); end
    end
    tick;
    n_checks++; if (gnt !== 4'b0010) begin n_errors++; $display("FAIL single_handoff: got %b expected 0010", gnt); end
  endtask

  task automatic test_rotate;
    logic [1:0] exp_idx;
    req = 4'b1111; out_ready = 1'b1;
    do_reset;
    for (int k = 1; k <= 20; k++) begin
      tick;
      exp_idx = 2'(((k - 1) / 4) % 4);
      n_checks++;
      if (gnt !== (4'b0001 << exp_idx) || {s1, s2} !== exp_idx) begin
        n_errors++; $display("FAIL rotate[%0d]: got gnt %b sel %b expected owner %0d", k, gnt, {s1, s2}, exp_idx);
      end
    end
  endtask

  task automatic test_drop;
    req = 4'b0010; out_ready = 1'b1;
    do_reset;
    tick;
    n_checks++; if (gnt !== 4'b0010) begin n_errors++; $display("FAIL drop_first: got %b expected 0010", gnt); end
    tick; tick;
    req = 4'b0101;
    #1;
    n_checks++; if (out_valid !== 1'b0 || o !== 8'h00) begin n_errors++; $display("FAIL drop_valid: got %b/%h expected 0/00", out_valid, o); end
    for (int k = 0; k < 4; k++) begin
      tick;
      n_checks++; if (gnt !== 4'b0100) begin n_errors++; $display("FAIL drop_grant2[%0d]: got %b expected 0100", k, gnt); end
    end
    tick;
    n_checks++; if (gnt !== 4'b0001) begin n_errors++; $display("FAIL drop_next: got %b expected 0001", gnt); end
  endtask

  task automatic test_stall;
    req = 4'b1000; out_ready = 1'b0;
    do_reset;
    tick;
    n_checks++; if (gnt !== 4'b1000 || {s1, s2} !== 2'b11) begin n_errors++; $display("FAIL stall_grant: got %b/%b expected 1000/11", gnt, {s1, s2}); end
    for (int k = 0; k < 20; k++) begin
      tick;
      n_checks++; if (gnt !== 4'b1000 || out_valid !== 1'b1) begin n_errors++; $display("FAIL stall_hold[%0d]: got %b/%b expected 1000/1", k, gnt, out_valid); end
    end
    out_ready = 1'b1; req = 4'b1001;
    for (int k = 0; k < 3; k++) begin
      tick;
      n_checks++; if (gnt !== 4'b1000) begin n_errors++; $display("FAIL stall_beats[%0d]: got %b expected 1000", k, gnt); end
    end
    tick;
    n_checks++; if (gnt !== 4'b0001) begin n_errors++; $display("FAIL stall_release: got %b expected 0001", gnt); end
  endtask

  task automatic test_reset_mid;
    req = 4'b0100; out_ready = 1'b1;
    do_reset;
    tick;
    n_checks++; if (gnt !== 4'b0100 || o !== c) begin n_errors++; $display("FAIL midrst_grant: got %b/%h expected 0100/%h", gnt, o, c); end
    req = 4'b1111;
    #2; rst_n = 1'b0; #1;
    n_checks++; if (gnt !== 4'b0000 || o !== 8'h00 || out_valid !== 1'b0) begin n_errors++; $display("FAIL midrst_async: got %b/%h/%b expected 0000/00/0", gnt, o, out_valid); end
    n_checks++; if ({s1, s2} !== 2'b00) begin n_errors++; $display("FAIL midrst_sel: got %b expected 00", {s1, s2}); end
    #3; rst_n = 1'b1;
    tick;
    n_checks++; if (gnt !== 4'b0001) begin n_errors++; $display("FAIL midrst_first: got %b expected 0001", gnt); end
  endtask

  task automatic test_random;
    logic [5:0]    exp;
    logic          exp_ov;
    logic [TW-1:0] exp_o;
    int            worst;
    req = 4'b0000; out_ready = 1'b1;
    do_reset;
    model_reset;
    exp_q.delete();
    for (int n = 0; n < 10000; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        for (int i = 0; i < 4; i++) req[i] = ($urandom_range(0, 9) < 7);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      a = 8'($urandom); b = 8'($urandom); c = 8'($urandom); d = 8'($urandom);
      #1;
      exp_ov = m_g && req[m_idx];
      exp_o  = exp_ov ? sel_data(m_idx) : 8'h00;
      n_checks++; if (out_valid !== exp_ov) begin n_errors++; $display("FAIL rnd_valid[%0d]: got %b expected %b", n, out_valid, exp_ov); end
      n_checks++; if (o !== exp_o) begin n_errors++; $display("FAIL rnd_o[%0d]: got %h expected %h", n, o, exp_o); end
      model_step;
      tick;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++; $display("FAIL rnd_queue[%0d]: got empty expected entry", n);
      end else begin
        exp = exp_q.pop_front();
        if (gnt !== exp[5:2] || {s1, s2} !== exp[1:0]) begin
          n_errors++; $display("FAIL rnd_grant[%0d]: got %b/%b expected %b/%b", n, gnt, {s1, s2}, exp[5:2], exp[1:0]);
        end
      end
      worst = 0;
      for (int i = 0; i < 4; i++) if (m_wait[i] > worst) worst = m_wait[i];
      n_checks++; if (worst > 3) begin n_errors++; $display("FAIL rnd_starve[%0d]: got %0d expected <=3", n, worst); end
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    test_reset;
    test_single;
    test_rotate;
    test_drop;
    test_stall;
    test_reset_mid;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
